adc_deser_decim: RTL and testbench
==================================

# adc_deser_decim

Multi-channel successor to the single-channel serial ADC front end. It recovers N_CH serial ADC streams that share a bit clock and word sync, all oversampled in the processing clock domain. It assembles SAMPLE_BITS-wide two's-complement words, publishes raw frames, and produces a boxcar-decimated average per channel. It also flags framing errors and reports ADC module presence with a watchdog.

## Interface
Parameters:
- N_CH, 4, number of serial data lanes sharing ADC_clock/ADC_word_sync
- SAMPLE_BITS, 18, bits per word, MSB first, two's complement
- LOG2_DECIM, 5, decimation factor is 2^LOG2_DECIM frames; 0 means no averaging
- TIMEOUT, 1023, processing_clock cycles without a complete frame before ADC_detection drops

Ports (one clock; reset is asynchronous and active-high):
- processing_clock  in  1  sole clock
- reset  in  1  asynchronous, active-high
- enable  in  1  decimator enable
- error_clear  in  1  clears frame_error
- ADC_clock  in  1  serial bit clock, asynchronous, sampled
- ADC_word_sync  in  1  frame marker, asynchronous, sampled
- ADC_serial_data  in  N_CH  serial lanes, asynchronous, sampled
- raw_data  out  N_CH*SAMPLE_BITS  last complete frame; lane k at [k*SAMPLE_BITS +: SAMPLE_BITS]
- raw_valid  out  1  one-cycle pulse per complete frame
- ADC_data  out  N_CH*SAMPLE_BITS  decimated average, same packing
- ADC_data_valid  out  1  one-cycle pulse per decimation window
- frame_error  out  1  sticky framing error
- ADC_detection  out  1  high while frames are arriving

## Operation
- Input capture: ADC_clock, ADC_word_sync and all lanes pass through identical 2-FF synchronisers. A bit event is a rising edge of the synchronised ADC_clock, detected via a third register.
- Framing: one bit per lane is captured per bit event (single data rate).
  - A bit event with synced word_sync high starts a frame. That event's bit is the MSB (bit SAMPLE_BITS-1), and the bit counter loads 1.
  - Each later event shifts the bit in and increments the counter.
  - When the counter reaches SAMPLE_BITS the frame is complete. The counter enters IDLE, and further events are ignored until the next sync.
  - Events before the first sync are ignored.
- Framing error: sync seen while 1 ≤ counter < SAMPLE_BITS.
  - The partial frame is discarded and frame_error is set.
  - That event restarts a new frame (it is the MSB).
- frame_error clears on error_clear. If error_clear and a new error occur in the same cycle, the error wins.
- Decimator: active only while enable=1.
  - Per lane, the accumulator is SAMPLE_BITS+LOG2_DECIM bits wide and sign-extended.
  - Each complete frame adds to the accumulator and increments the frame counter.
  - On the 2^LOG2_DECIM-th frame, ADC_data is set to (acc+sample) >>> LOG2_DECIM, which is arithmetic and truncates toward −inf. ADC_data_valid pulses, and the accumulators reload to zero with the counter at 0.
- enable=0:
  - Accumulators and frame counter are held at 0, and ADC_data_valid stays 0.
  - ADC_data holds its last value.
  - The raw path and detection are unaffected.
- A window begins with the first frame completing after enable rises.
- Watchdog: counter cleared and ADC_detection set to 1 on each complete frame. The counter saturates at TIMEOUT, and at that point ADC_detection goes to 0.

## Timing
- Reset values: all outputs 0, all counters and accumulators 0, framer IDLE.
- Reset mid-frame or mid-window discards all partial state. The first window after release needs 2^LOG2_DECIM full frames.
- Input requirement: ADC_clock high and low each ≥ 2 processing_clock cycles. Data and sync must be stable ≥ 2 cycles around ADC_clock rising edges.
- Cycle E is the processing_clock cycle in which the final bit event of a frame is detected. Pin-to-E is 3 cycles.
- raw_data/raw_valid are registered at E+1. ADC_detection is set at E+1.
- ADC_data/ADC_data_valid are registered at E+2 for the closing frame of a window.
- For LOG2_DECIM=0, ADC_data equals raw_data, one cycle later.
- frame_error rises at (sync event cycle)+1.

## Test plan
- Frame with N_CH=2, SAMPLE_BITS=18, lane0=18'h2AAAA, lane1=18'h3FFFF -> raw_data lanes 0x2AAAA/0x3FFFF; exactly one raw_valid pulse at E+1; frame_error stays 0.
- LOG2_DECIM=2, lane0 frames 4,8,12,16; lane1 −1,−1,−1,−2 -> one ADC_data_valid at E+2 of frame 4; lane0=10, lane1=0x3FFFE (−2); no valid after frames 1–3.
- Sync reasserted after 7 bits, followed by a full frame of 0x00005 -> frame_error=1, no raw_valid for the truncated frame, raw lane0=0x00005 next; error_clear pulse -> frame_error=0; error_clear coincident with a new error -> stays 1.
- TIMEOUT=50; frames then ADC_clock stopped -> ADC_detection=1 after first frame and falls exactly 50 cycles after the last frame's E+1.
- Reset asserted after 2 of 4 frames -> all outputs 0 immediately; after release, ADC_data_valid only after 4 new frames, average excludes pre-reset data.
- enable=0 across 8 frames -> raw_valid 8 pulses, no ADC_data_valid; enable=1 -> first valid after 4 subsequent frames.

Source files
------------

// File: rtl/adc_deser_decim.sv
// Multi-lane serial ADC deserialiser: oversampled bit/word capture, raw frame output,
// per-lane boxcar decimation, sticky framing-error flag and a presence watchdog.
module adc_deser_decim #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned SAMPLE_BITS = 18,
    parameter int unsigned LOG2_DECIM  = 5,
    parameter int unsigned TIMEOUT     = 1023
) (
    input  logic                          processing_clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          error_clear,
    input  logic                          ADC_clock,
    input  logic                          ADC_word_sync,
    input  logic [N_CH-1:0]               ADC_serial_data,
    output logic [N_CH*SAMPLE_BITS-1:0]   raw_data,
    output logic                          raw_valid,
    output logic [N_CH*SAMPLE_BITS-1:0]   ADC_data,
    output logic                          ADC_data_valid,
    output logic                          frame_error,
    output logic                          ADC_detection
);

    localparam int unsigned SW = N_CH + 2;
    localparam int unsigned CW = $clog2(SAMPLE_BITS + 1);
    localparam int unsigned AW = SAMPLE_BITS + LOG2_DECIM;
    localparam int unsigned DW = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_BIT   = CW'(SAMPLE_BITS - 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(SAMPLE_BITS);
    localparam logic [DW-1:0] DECIM_LAST = DW'((1 << LOG2_DECIM) - 1);
    localparam logic [TW-1:0] WD_MAX     = TW'(TIMEOUT);

    typedef enum logic {IDLE, RECV} fr_state_e;

    fr_state_e state_q, state_d;

    logic [SW-1:0]                         sync1_q, sync1_d, sync2_q, sync2_d;
    logic                                  bclk_prev_q, bclk_prev_d;
    logic [CW-1:0]                         bit_cnt_q, bit_cnt_d;
    logic [N_CH-1:0][SAMPLE_BITS-1:0]      shift_q, shift_d;
    logic [N_CH-1:0][SAMPLE_BITS-1:0]      raw_data_q, raw_data_d;
    logic                                  raw_valid_q, raw_valid_d;
    logic                                  frame_error_q, frame_error_d;
    logic [TW-1:0]                         wd_cnt_q, wd_cnt_d;
    logic                                  detect_q, detect_d;
    logic [N_CH-1:0][AW-1:0]               acc_q, acc_d;
    logic [DW-1:0]                         dcnt_q, dcnt_d;
    logic [N_CH-1:0][SAMPLE_BITS-1:0]      adc_data_q, adc_data_d;
    logic                                  adc_valid_q, adc_valid_d;

    logic signed [AW-1:0] sum_w [N_CH];
    logic                 bclk_s, bsync_s, bit_event;
    logic [N_CH-1:0]      bdata_s;
    logic                 start, advance, frame_done, err_evt;

    assign bclk_s    = sync2_q[SW-1];
    assign bsync_s   = sync2_q[SW-2];
    assign bdata_s   = sync2_q[N_CH-1:0];
    assign bit_event = bclk_s & ~bclk_prev_q;

    // Framer state register
    always_ff @(posedge processing_clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Framer next state
    always_comb begin
        state_d = state_q;
        if (bit_event) begin
            if (bsync_s)
                state_d = (SAMPLE_BITS == 1) ? IDLE : RECV;
            else if (state_q == RECV && bit_cnt_q == LAST_BIT)
                state_d = IDLE;
        end
    end

    // Framer outputs: a sync while receiving discards the partial word and restarts at the MSB
    always_comb begin
        start      = bit_event & bsync_s;
        advance    = bit_event & ~bsync_s & (state_q == RECV);
        err_evt    = start & (state_q == RECV);
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        if (start) begin
            bit_cnt_d = CW'(1);
            for (int unsigned k = 0; k < N_CH; k++)
                shift_d[k] = SAMPLE_BITS'(bdata_s[k]);
        end else if (advance) begin
            bit_cnt_d = bit_cnt_q + CW'(1);
            for (int unsigned k = 0; k < N_CH; k++)
                shift_d[k] = {shift_q[k][SAMPLE_BITS-2:0], bdata_s[k]};
        end
        frame_done = (start | advance) & (bit_cnt_d == FULL_CNT);
        if (frame_done)
            bit_cnt_d = '0;
    end

    always_comb begin
        sync1_d     = {ADC_clock, ADC_word_sync, ADC_serial_data};
        sync2_d     = sync1_q;
        bclk_prev_d = bclk_s;

        raw_valid_d = frame_done;
        raw_data_d  = frame_done ? shift_d : raw_data_q;

        frame_error_d = err_evt ? 1'b1 : (error_clear ? 1'b0 : frame_error_q);

        if (frame_done) begin
            wd_cnt_d = '0;
            detect_d = 1'b1;
        end else begin
            wd_cnt_d = (wd_cnt_q == WD_MAX) ? wd_cnt_q : wd_cnt_q + TW'(1);
            detect_d = (wd_cnt_d == WD_MAX) ? 1'b0 : detect_q;
        end

        // Decimator runs one cycle behind the raw register
        for (int unsigned k = 0; k < N_CH; k++)
            sum_w[k] = $signed(acc_q[k]) + AW'($signed(raw_data_q[k]));
        acc_d       = acc_q;
        dcnt_d      = dcnt_q;
        adc_data_d  = adc_data_q;
        adc_valid_d = 1'b0;
        if (!enable) begin
            acc_d  = '0;
            dcnt_d = '0;
        end else if (raw_valid_q) begin
            if (dcnt_q == DECIM_LAST) begin
                for (int unsigned k = 0; k < N_CH; k++)
                    adc_data_d[k] = SAMPLE_BITS'(sum_w[k] >>> LOG2_DECIM);
                adc_valid_d = 1'b1;
                acc_d       = '0;
                dcnt_d      = '0;
            end else begin
                for (int unsigned k = 0; k < N_CH; k++)
                    acc_d[k] = sum_w[k];
                dcnt_d = dcnt_q + DW'(1);
            end
        end
    end

    always_ff @(posedge processing_clock or posedge reset) begin
        if (reset) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            bclk_prev_q   <= 1'b0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            raw_data_q    <= '0;
            raw_valid_q   <= 1'b0;
            frame_error_q <= 1'b0;
            wd_cnt_q      <= '0;
            detect_q      <= 1'b0;
            acc_q         <= '0;
            dcnt_q        <= '0;
            adc_data_q    <= '0;
            adc_valid_q   <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            bclk_prev_q   <= bclk_prev_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            raw_data_q    <= raw_data_d;
            raw_valid_q   <= raw_valid_d;
            frame_error_q <= frame_error_d;
            wd_cnt_q      <= wd_cnt_d;
            detect_q      <= detect_d;
            acc_q         <= acc_d;
            dcnt_q        <= dcnt_d;
            adc_data_q    <= adc_data_d;
            adc_valid_q   <= adc_valid_d;
        end
    end

    assign raw_data       = raw_data_q;
    assign raw_valid      = raw_valid_q;
    assign ADC_data       = adc_data_q;
    assign ADC_data_valid = adc_valid_q;
    assign frame_error    = frame_error_q;
    assign ADC_detection  = detect_q;

endmodule

// File: tb/tb_adc_deser_decim.sv
// Bench for adc_deser_decim: serial frames driven bit by bit, checked against a
// frame-level arithmetic model of raw capture, windowed averaging and watchdog.
module tb_adc_deser_decim;

    localparam int unsigned N_CH = 2;
    localparam int unsigned SB   = 18;
    localparam int unsigned L    = 2;
    localparam int unsigned TO   = 50;
    localparam int unsigned D    = 1 << L;
    localparam int unsigned FW   = N_CH * SB;

    logic            clk = 1'b0;
    logic            reset, enable, error_clear;
    logic            ADC_clock, ADC_word_sync;
    logic [N_CH-1:0] ADC_serial_data;
    logic [FW-1:0]   raw_data, ADC_data;
    logic            raw_valid, ADC_data_valid, frame_error, ADC_detection;

    always #5 clk = ~clk;

    adc_deser_decim #(
        .N_CH(N_CH), .SAMPLE_BITS(SB), .LOG2_DECIM(L), .TIMEOUT(TO)
    ) dut (
        .processing_clock(clk),
        .reset(reset),
        .enable(enable),
        .error_clear(error_clear),
        .ADC_clock(ADC_clock),
        .ADC_word_sync(ADC_word_sync),
        .ADC_serial_data(ADC_serial_data),
        .raw_data(raw_data),
        .raw_valid(raw_valid),
        .ADC_data(ADC_data),
        .ADC_data_valid(ADC_data_valid),
        .frame_error(frame_error),
        .ADC_detection(ADC_detection)
    );

    int unsigned checks = 0, failures = 0;
    int unsigned cyc = 0, raw_cnt = 0, dv_cnt = 0, last_raw_cyc = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor samples just after each active edge
    always @(posedge clk) begin
        #1;
        cyc++;
        if (raw_valid) begin
            raw_cnt++;
            last_raw_cyc = cyc;
            check_eq("det_on_raw", 64'(ADC_detection), 64'd1);
        end
        if (ADC_data_valid) begin
            dv_cnt++;
            check_eq("dv_latency", 64'(cyc - last_raw_cyc), 64'd1);
        end
    end

    // Frame-level reference model of the decimator
    longint        m_sum [N_CH];
    int unsigned   m_n = 0;
    int unsigned   exp_dv_cnt = 0;
    logic [FW-1:0] exp_adc = '0;

    function automatic void model_clear();
        for (int unsigned k = 0; k < N_CH; k++) m_sum[k] = 0;
        m_n = 0;
    endfunction

    function automatic void model_frame(input logic [FW-1:0] f);
        logic [SB-1:0] w;
        longint q;
        if (!enable) return;
        for (int unsigned k = 0; k < N_CH; k++) begin
            w = f[k*SB +: SB];
            m_sum[k] += longint'($signed(w));
        end
        m_n++;
        if (m_n == D) begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                q = m_sum[k] / longint'(D);
                if ((m_sum[k] % longint'(D)) != 0 && m_sum[k] < 0) q -= 1;
                exp_adc[k*SB +: SB] = q[SB-1:0];
            end
            exp_dv_cnt++;
            model_clear();
        end
    endfunction

    task automatic send_bit(input logic [N_CH-1:0] b, input logic s);
        @(negedge clk);
        ADC_serial_data = b;
        ADC_word_sync   = s;
        repeat (3) @(negedge clk);
        ADC_clock = 1'b1;
        repeat (3) @(negedge clk);
        ADC_clock = 1'b0;
    endtask

    task automatic send_frame(input logic [FW-1:0] f, input int unsigned nbits);
        logic [N_CH-1:0] b;
        for (int unsigned i = 0; i < nbits; i++) begin
            for (int unsigned k = 0; k < N_CH; k++) b[k] = f[k*SB + SB - 1 - i];
            send_bit(b, i == 0);
        end
    endtask

    task automatic do_frame(input logic [FW-1:0] f);
        int unsigned c0;
        c0 = raw_cnt;
        send_frame(f, SB);
        for (int unsigned i = 0; i < 20 && raw_cnt == c0; i++) @(negedge clk);
        check_eq("raw_count", 64'(raw_cnt), 64'(c0 + 1));
        check_eq("raw_data", 64'(raw_data), 64'(f));
        model_frame(f);
        repeat (2) @(negedge clk);
        check_eq("dv_count", 64'(dv_cnt), 64'(exp_dv_cnt));
        check_eq("adc_data", 64'(ADC_data), 64'(exp_adc));
    endtask

    task automatic set_enable(input logic v);
        @(negedge clk);
        enable = v;
        model_clear();
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_raw_data", 64'(raw_data), 64'd0);
        check_eq("rst_raw_valid", 64'(raw_valid), 64'd0);
        check_eq("rst_adc_data", 64'(ADC_data), 64'd0);
        check_eq("rst_adc_valid", 64'(ADC_data_valid), 64'd0);
        check_eq("rst_frame_error", 64'(frame_error), 64'd0);
        check_eq("rst_detection", 64'(ADC_detection), 64'd0);
    endtask

    function automatic logic [FW-1:0] rand_frame();
        logic [FW-1:0] f;
        for (int unsigned k = 0; k < N_CH; k++) f[k*SB +: SB] = SB'($urandom);
        return f;
    endfunction

    function automatic logic [FW-1:0] pack2(input logic [SB-1:0] l0, input logic [SB-1:0] l1);
        return {l1, l0};
    endfunction

    logic [FW-1:0] fr;
    int unsigned   c0;

    initial begin
        reset = 1'b1; enable = 1'b0; error_clear = 1'b0;
        ADC_clock = 1'b0; ADC_word_sync = 1'b0; ADC_serial_data = '0;
        model_clear();
        repeat (3) @(negedge clk);
        check_reset_outputs();
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Directed single frame, decimator off
        do_frame(pack2(18'h2AAAA, 18'h3FFFF));
        check_eq("no_err_after_frame", 64'(frame_error), 64'd0);

        // Directed window: lane0 4,8,12,16 ; lane1 -1,-1,-1,-2
        set_enable(1'b1);
        do_frame(pack2(18'd4,  18'h3FFFF));
        do_frame(pack2(18'd8,  18'h3FFFF));
        do_frame(pack2(18'd12, 18'h3FFFF));
        do_frame(pack2(18'd16, 18'h3FFFE));
        check_eq("dir_lane0_avg", 64'(ADC_data[0 +: SB]), 64'h0000A);
        check_eq("dir_lane1_avg", 64'(ADC_data[SB +: SB]), 64'h3FFFE);

        // Random windows, then extreme-value windows
        for (int unsigned i = 0; i < 5 * D; i++) do_frame(rand_frame());
        for (int unsigned i = 0; i < D; i++) do_frame(pack2(18'h20000, 18'h20000));
        for (int unsigned i = 0; i < D; i++) do_frame(pack2(18'h1FFFF, 18'h20000 + 18'(i)));

        // Decimator disabled across 8 frames, then a fresh window
        set_enable(1'b0);
        c0 = raw_cnt;
        for (int unsigned i = 0; i < 8; i++) do_frame(rand_frame());
        check_eq("raw_while_disabled", 64'(raw_cnt - c0), 64'd8);
        set_enable(1'b1);
        for (int unsigned i = 0; i < D; i++) do_frame(rand_frame());

        // Framing error: sync after 7 bits, then a full frame
        set_enable(1'b0);
        c0 = raw_cnt;
        send_frame(rand_frame(), 7);
        repeat (10) @(negedge clk);
        check_eq("trunc_no_raw", 64'(raw_cnt), 64'(c0));
        check_eq("err_before_sync", 64'(frame_error), 64'd0);
        do_frame(pack2(18'h00005, 18'h00000));
        check_eq("err_set", 64'(frame_error), 64'd1);
        @(negedge clk); error_clear = 1'b1;
        @(negedge clk); error_clear = 1'b0;
        @(negedge clk);
        check_eq("err_cleared", 64'(frame_error), 64'd0);

        // Clear held until the new error lands in the same cycle
        error_clear = 1'b1;
        fork
            begin
                send_frame(rand_frame(), 7);
                do_frame(rand_frame());
            end
            begin
                for (int unsigned i = 0; i < 2000 && !frame_error; i++) @(negedge clk);
                error_clear = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        check_eq("err_beats_clear", 64'(frame_error), 64'd1);

        // Reset mid-window discards partial accumulation
        set_enable(1'b1);
        do_frame(rand_frame());
        do_frame(rand_frame());
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_outputs();
        model_clear();
        exp_adc = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int unsigned i = 0; i < D; i++) do_frame(rand_frame());

        // Watchdog: detection falls TIMEOUT cycles after the last raw_valid
        do_frame(rand_frame());
        for (int unsigned i = 0; i < 300 && ADC_detection; i++) @(negedge clk);
        check_eq("wd_fell", 64'(ADC_detection), 64'd0);
        check_eq("wd_gap", 64'(cyc - last_raw_cyc), 64'(TO));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
